// File: rtl/half_ip_sched_if.sv
// Request/result handshake bundle between a requester and the half-pel
// interpolator sequencer. Requests carry an integer-pel centre address.
// Results carry nine captured half-pel samples plus an out-of-range flag.
interface half_ip_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_centre;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_half;
  logic [7:0]  out_centre;
  logic        out_err;

  // Requester side: issues centres and consumes results.
  modport master (
    output req_valid, req_centre, out_ready,
    input  req_ready, out_valid, out_half, out_centre, out_err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_centre, out_ready,
    output req_ready, out_valid, out_half, out_centre, out_err
  );
endinterface

// File: rtl/half_ip_sched.sv
// Sequencer for the half-pel interpolator. It accepts one centre address at a time
// and rejects centres whose filter footprint would leave the 16x16 macroblock.
// For a legal centre it restarts the interpolator for one cycle and lets it run
// for IP_LATENCY cycles. It then captures the nine results and holds them until
// they are consumed. The interpolator is held in reset whenever it is not running.
module half_ip_sched #(
  parameter int IP_LATENCY = 26,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  half_ip_sched_if.slave     bus,
  output logic               ip_rst_n,
  output logic [7:0]         ip_centre,
  input  logic [71:0]        ip_half,
  output logic [COUNT_W-1:0] job_count
);

  localparam int RUN_W = (IP_LATENCY > 1) ? $clog2(IP_LATENCY) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(IP_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic             take;
  logic             legal_in;

  // A centre is launchable only if taps at rows -4..+3 and cols -3..+3
  // stay inside the macroblock, because interpolator addressing wraps at 8 bits.
  function automatic logic centre_legal(input logic [7:0] c);
    logic [3:0] row;
    logic [3:0] col;
    row = c[7:4];
    col = c[3:0];
    return (row >= 4'd4) && (row <= 4'd12) && (col >= 4'd3) && (col <= 4'd12);
  endfunction

  // Ready in IDLE, or in DONE when the current result leaves this cycle.
  always_comb begin
    take = 1'b0;
    if (rst) begin
      take = 1'b0;
    end else begin
      case (state)
        IDLE:    take = 1'b1;
        DONE:    take = bus.out_ready;
        default: take = 1'b0;
      endcase
    end
  end

  assign bus.req_ready = take;
  assign legal_in      = centre_legal(bus.req_centre);

  // Job sequencing: restart pulse, timed run, capture, and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      run_cnt       <= '0;
      ip_rst_n      <= 1'b0;
      ip_centre     <= 8'd0;
      bus.out_valid <= 1'b0;
      bus.out_half  <= 72'd0;
      bus.out_centre<= 8'd0;
      bus.out_err   <= 1'b0;
      job_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ip_rst_n <= 1'b0;
        end
        RESTART: begin
          ip_rst_n <= 1'b1;
          run_cnt  <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (run_cnt == RUN_LAST) begin
            ip_rst_n      <= 1'b0;
            bus.out_half  <= ip_half;
            bus.out_err   <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            run_cnt <= run_cnt + {{(RUN_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            job_count     <= job_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state    <= IDLE;
          ip_rst_n <= 1'b0;
        end
      endcase

      // A new job can be taken from IDLE or in the same cycle a result is consumed.
      // Later assignments here take precedence over the DONE -> IDLE exit above.
      if (take && bus.req_valid) begin
        ip_centre      <= bus.req_centre;
        bus.out_centre <= bus.req_centre;
        if (legal_in) begin
          state <= RESTART;
        end else begin
          state         <= DONE;
          bus.out_valid <= 1'b1;
          bus.out_err   <= 1'b1;
          bus.out_half  <= 72'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_half_ip_sched.sv
// Bench for half_ip_sched. A transaction/timestamp model predicts every output
// from the acceptance time of the job in flight. Directed scenarios pin the
// model with literal expectations, and a randomized phase follows.
module tb_half_ip_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        ip_rst_n;
  logic [7:0]  ip_centre;
  logic [71:0] ip_half;
  logic [3:0]  job_count;

  half_ip_sched_if bus();

  half_ip_sched #(.IP_LATENCY(26), .COUNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .ip_rst_n  (ip_rst_n),
    .ip_centre (ip_centre),
    .ip_half   (ip_half),
    .job_count (job_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic check_en = 1'b0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_legal(input int c);
    int r;
    int k;
    r = c / 16;
    k = c % 16;
    return (r >= 4) && (r <= 12) && (k >= 3) && (k <= 12);
  endfunction

  // Behavioural model: one job in flight, described by its acceptance time.
  logic        m_has    = 1'b0;
  logic        m_legal  = 1'b0;
  int          m_acc    = 0;
  logic [7:0]  m_centre = 8'd0;
  logic [7:0]  m_ipc    = 8'd0;
  logic [71:0] m_half   = 72'd0;
  logic [3:0]  m_count  = 4'd0;
  int          t        = 0;
  logic        ev;
  logic        er;
  logic        eip;
  logic        last_fire = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      ev  = m_has && (t >= m_acc + (m_legal ? 28 : 1));
      er  = !rst && (!m_has || (ev && bus.out_ready));
      eip = m_has && m_legal && (t - m_acc >= 2) && (t - m_acc <= 27);
      if (check_en) begin
        chk("req_ready", 72'(bus.req_ready), 72'(er));
        chk("out_valid", 72'(bus.out_valid), 72'(ev));
        chk("ip_rst_n", 72'(ip_rst_n), 72'(eip));
        chk("ip_centre", 72'(ip_centre), 72'(m_ipc));
        chk("job_count", 72'(job_count), 72'(m_count));
        if (ev) begin
          chk("out_half", bus.out_half, m_legal ? m_half : 72'd0);
          chk("out_centre", 72'(bus.out_centre), 72'(m_centre));
          chk("out_err", 72'(bus.out_err), 72'(!m_legal));
        end
      end
      if (m_has && m_legal && (t - m_acc == 27)) m_half = ip_half;
      last_fire = bus.req_valid && er;
      if (rst) begin
        m_has   = 1'b0;
        m_count = 4'd0;
        m_ipc   = 8'd0;
      end else begin
        if (ev && bus.out_ready) begin
          m_has   = 1'b0;
          m_count = m_count + 4'd1;
        end
        if (bus.req_valid && er) begin
          m_has    = 1'b1;
          m_acc    = t;
          m_centre = bus.req_centre;
          m_ipc    = bus.req_centre;
          m_legal  = is_legal(int'(bus.req_centre));
        end
      end
      t++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [71:0] k_half;
  int n;
  int runs;
  int c;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_centre = 8'd0;
    bus.out_ready = 1'b0;
    ip_half = 72'd0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
    chk("rst_req_ready", 72'(bus.req_ready), 72'd0);
    chk("rst_ip_rst_n", 72'(ip_rst_n), 72'd0);
    chk("rst_job_count", 72'(job_count), 72'd0);
    chk("rst_out_half", bus.out_half, 72'd0);
    rst = 1'b0;
    step();
    chk("idle_req_ready", 72'(bus.req_ready), 72'd1);

    // Legal centre 0x88: 26 run cycles, result in cycle 28.
    k_half = 72'h0123456789abcdef55;
    ip_half = k_half;
    bus.req_valid = 1'b1;
    bus.req_centre = 8'h88;
    bus.out_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("t1_ip_centre", 72'(ip_centre), 72'h88);
    chk("t1_restart_low", 72'(ip_rst_n), 72'd0);
    n = 1;
    runs = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
      if (ip_rst_n) runs++;
    end
    chk("t1_latency", 72'(n), 72'd28);
    chk("t1_run_cycles", 72'(runs), 72'd26);
    chk("t1_out_half", bus.out_half, k_half);
    chk("t1_out_err", 72'(bus.out_err), 72'd0);
    chk("t1_out_centre", 72'(bus.out_centre), 72'h88);
    step();
    chk("t1_job_count", 72'(job_count), 72'd1);

    // Illegal centres: row 3, then col 13 accepted in the DONE handshake cycle.
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_centre = 8'h30;
    step();
    chk("t2_valid", 72'(bus.out_valid), 72'd1);
    chk("t2_err", 72'(bus.out_err), 72'd1);
    chk("t2_half", bus.out_half, 72'd0);
    bus.req_centre = 8'h8D;
    repeat (10) step();
    chk("t3_hold_count", 72'(job_count), 72'd1);
    chk("t3_hold_centre", 72'(bus.out_centre), 72'h30);
    bus.out_ready = 1'b1;
    step();
    chk("t2_count", 72'(job_count), 72'd2);
    chk("t2_centre2", 72'(bus.out_centre), 72'h8D);
    bus.req_valid = 1'b0;
    step();
    chk("t2_drain", 72'(job_count), 72'd3);

    // Reset in the middle of a run aborts the job.
    bus.req_valid = 1'b1;
    bus.req_centre = 8'h88;
    step();
    bus.req_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_count", 72'(job_count), 72'd0);
    chk("t5_valid", 72'(bus.out_valid), 72'd0);
    chk("t5_ip_rst_n", 72'(ip_rst_n), 72'd0);
    step();
    chk("t5_ready", 72'(bus.req_ready), 72'd1);
    repeat (30) step();

    // Sixteen illegal jobs wrap the 4-bit counter.
    bus.req_valid = 1'b1;
    bus.req_centre = 8'h00;
    step();
    repeat (15) step();
    chk("t6_count15", 72'(job_count), 72'd15);
    step();
    chk("t6_wrap", 72'(job_count), 72'd0);
    bus.req_valid = 1'b0;
    repeat (2) step();

    // Randomized traffic with backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      ip_half = {$urandom, $urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      if (!bus.req_valid || last_fire) begin
        bus.req_valid = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 1) == 1) begin
          c = 16 * $urandom_range(4, 12) + $urandom_range(3, 12);
        end else begin
          c = $urandom_range(0, 255);
        end
        bus.req_centre = 8'(c);
      end
      step();
    end
    rst = 1'b0;
    bus.req_valid = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
